// File: rtl/sort_pkg.sv
// Shared state encoding and ordering rule for the bubble-sort engine.
package sort_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    COMPARE = 4'b0010,
    SWAP    = 4'b0100,
    DONE    = 4'b1000
  } state_t;

  localparam int MAXW = 64;

  // Strict comparison: equal values never count as out of order, keeping the sort stable.
  function automatic logic out_of_order(input logic [MAXW-1:0] a,
                                        input logic [MAXW-1:0] b,
                                        input logic            desc);
    return desc ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/sort_cmp.sv
// Combinational pair comparator: flags a pair that must be exchanged for the requested order.
module sort_cmp
  import sort_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic         ooo
);

  logic [MAXW-1:0] a_ext;
  logic [MAXW-1:0] b_ext;

  assign a_ext = MAXW'(a);
  assign b_ext = MAXW'(b);
  assign ooo   = out_of_order(a_ext, b_ext, desc);

endmodule

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort over a loadable N x W register file with early exit,
// run/step advance and saturating swap/pass statistics.
module bubble_sort_engine
  import sort_pkg::*;
#(
  parameter int N    = 32,
  parameter int W    = 8,
  parameter int CNTW = 16,
  localparam int IDXW = $clog2(N)
) (
  input  logic            board_clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [IDXW-1:0] load_idx,
  input  logic [W-1:0]    load_data,
  input  logic            start,
  input  logic            run,
  input  logic            step,
  input  logic            descending,
  input  logic            ack,
  input  logic [IDXW-1:0] rd_idx,
  output logic [W-1:0]    rd_data,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] cur_idx,
  output logic [IDXW-1:0] last_idx,
  output logic [CNTW-1:0] swaps,
  output logic [CNTW-1:0] passes
);

  if (N < 2) begin : g_bad_n
    $error("bubble_sort_engine: N must be at least 2");
  end

  state_t          state;
  logic [W-1:0]    mem [N];
  logic [IDXW-1:0] i;
  logic [IDXW-1:0] last;
  logic [IDXW-1:0] i_nxt;
  logic            swapped;
  logic            desc_q;
  logic            adv;
  logic            ooo;
  logic            pass_end;

  assign adv      = run | step;
  assign i_nxt    = i + IDXW'(1);
  assign pass_end = (i_nxt == last);

  sort_cmp #(.W(W)) u_cmp (
    .a    (mem[i]),
    .b    (mem[i_nxt]),
    .desc (desc_q),
    .ooo  (ooo)
  );

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      last    <= '0;
      swapped <= 1'b0;
      desc_q  <= 1'b0;
      swaps   <= '0;
      passes  <= '0;
      for (int k = 0; k < N; k++) mem[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) mem[load_idx] <= load_data;
          if (start) begin
            i       <= '0;
            last    <= IDXW'(N - 1);
            swapped <= 1'b0;
            swaps   <= '0;
            passes  <= '0;
            desc_q  <= descending;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (adv) begin
            if (ooo) begin
              state <= SWAP;
            end else if (!pass_end) begin
              i <= i_nxt;
            end else begin
              if (passes != '1) passes <= passes + CNTW'(1);
              if (last == IDXW'(1) || !swapped) begin
                state <= DONE;
              end else begin
                i       <= '0;
                last    <= last - IDXW'(1);
                swapped <= 1'b0;
              end
            end
          end
        end
        SWAP: begin
          mem[i]     <= mem[i_nxt];
          mem[i_nxt] <= mem[i];
          if (swaps != '1) swaps <= swaps + CNTW'(1);
          swapped <= 1'b1;
          // The pass just swapped, so only reaching the bottom of the array ends the sort here.
          if (!pass_end) begin
            i     <= i_nxt;
            state <= COMPARE;
          end else begin
            if (passes != '1) passes <= passes + CNTW'(1);
            if (last == IDXW'(1)) begin
              state <= DONE;
            end else begin
              i       <= '0;
              last    <= last - IDXW'(1);
              swapped <= 1'b0;
              state   <= COMPARE;
            end
          end
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data  = mem[rd_idx];
  assign busy     = (state == COMPARE) || (state == SWAP);
  assign done     = (state == DONE);
  assign cur_idx  = i;
  assign last_idx = last;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed checks of the bubble-sort engine with N=4, W=8.
module tb_bubble_sort_engine;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int CNTW = 16;
  localparam int IDXW = 2;

  logic            board_clk = 1'b0;
  logic            reset     = 1'b1;
  logic            load_en   = 1'b0;
  logic [IDXW-1:0] load_idx  = '0;
  logic [W-1:0]    load_data = '0;
  logic            start     = 1'b0;
  logic            run       = 1'b1;
  logic            step      = 1'b0;
  logic            descending = 1'b0;
  logic            ack       = 1'b0;
  logic [IDXW-1:0] rd_idx    = '0;
  logic [W-1:0]    rd_data;
  logic            busy;
  logic            done;
  logic [IDXW-1:0] cur_idx;
  logic [IDXW-1:0] last_idx;
  logic [CNTW-1:0] swaps;
  logic [CNTW-1:0] passes;

  int errors = 0;
  int checks = 0;

  bubble_sort_engine #(.N(N), .W(W), .CNTW(CNTW)) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .start      (start),
    .run        (run),
    .step       (step),
    .descending (descending),
    .ack        (ack),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .cur_idx    (cur_idx),
    .last_idx   (last_idx),
    .swaps      (swaps),
    .passes     (passes)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge board_clk);
    #1;
  endtask

  // Writes four elements; optionally raises start together with the final write.
  task automatic load4(input logic [7:0] v0, input logic [7:0] v1,
                       input logic [7:0] v2, input logic [7:0] v3,
                       input logic start_with_last);
    logic [7:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int k = 0; k < 4; k++) begin
      load_en   = 1'b1;
      load_idx  = IDXW'(k);
      load_data = v[k];
      if (k == 3 && start_with_last) start = 1'b1;
      cyc();
    end
    load_en = 1'b0;
    start   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cnt);
    cnt = 0;
    while (!done && cnt < 200) begin
      cyc();
      cnt++;
    end
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_mem4(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      rd_idx = IDXW'(k);
      #1;
      chk($sformatf("%s_mem%0d", tag, k), 32'(rd_data), 32'(e[k]));
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  initial begin
    int cnt;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_swaps", 32'(swaps), 32'd0);
    check_mem4("rst", 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge board_clk);
    reset = 1'b0;
    cyc();

    // 1: reverse ascending
    load4(8'd4, 8'd3, 8'd2, 8'd1, 1'b0);
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", cnt);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_swaps", 32'(swaps), 32'd6);
    chk("t1_passes", 32'(passes), 32'd3);
    check_mem4("t1", 8'd1, 8'd2, 8'd3, 8'd4);
    do_ack();

    // 2: sorted input exits after one pass of N-1 compares
    load4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    pulse_start();
    wait_done("t2", cnt);
    chk("t2_cycles", 32'(cnt), 32'd3);
    chk("t2_swaps", 32'(swaps), 32'd0);
    chk("t2_passes", 32'(passes), 32'd1);
    do_ack();

    // 3: descending, start coinciding with the last write
    descending = 1'b1;
    load4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    descending = 1'b0;
    wait_done("t3", cnt);
    chk("t3_swaps", 32'(swaps), 32'd6);
    check_mem4("t3", 8'd4, 8'd3, 8'd2, 8'd1);
    do_ack();

    // 4: single-step freeze, then one step
    run = 1'b0;
    load4(8'd4, 8'd3, 8'd2, 8'd1, 1'b0);
    pulse_start();
    repeat (20) cyc();
    chk("t4_idx_frozen", 32'(cur_idx), 32'd0);
    chk("t4_busy_frozen", 32'(busy), 32'd1);
    chk("t4_swaps_frozen", 32'(swaps), 32'd0);
    check_mem4("t4_frozen", 8'd4, 8'd3, 8'd2, 8'd1);
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (5) cyc();
    chk("t4_step_idx", 32'(cur_idx), 32'd1);
    chk("t4_step_swaps", 32'(swaps), 32'd1);
    check_mem4("t4_step", 8'd3, 8'd4, 8'd2, 8'd1);
    run = 1'b1;
    wait_done("t4", cnt);
    check_mem4("t4_end", 8'd1, 8'd2, 8'd3, 8'd4);
    do_ack();

    // 5: duplicates stay stable; load ignored in DONE; ack keeps contents
    load4(8'd2, 8'd2, 8'd1, 8'd1, 1'b0);
    pulse_start();
    wait_done("t5", cnt);
    chk("t5_swaps", 32'(swaps), 32'd4);
    chk("t5_passes", 32'(passes), 32'd3);
    load_en = 1'b1; load_idx = '0; load_data = 8'd99;
    cyc();
    load_en = 1'b0;
    chk("t5_done_held", 32'(done), 32'd1);
    do_ack();
    chk("t5_ack_done", 32'(done), 32'd0);
    chk("t5_ack_busy", 32'(busy), 32'd0);
    check_mem4("t5", 8'd1, 8'd1, 8'd2, 8'd2);

    // 6: asynchronous reset while in SWAP
    run = 1'b0;
    load4(8'd4, 8'd3, 8'd2, 8'd1, 1'b0);
    pulse_start();
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("t6_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_idx", 32'(cur_idx), 32'd0);
    chk("t6_last", 32'(last_idx), 32'd0);
    chk("t6_swaps", 32'(swaps), 32'd0);
    chk("t6_passes", 32'(passes), 32'd0);
    check_mem4("t6", 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge board_clk);
    reset = 1'b0;
    run   = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
